wex_bundle_issue: RTL and testbench
===================================

# wex_bundle_issue

Fetch-to-decode issue sequencer for the 3-wide WEX decoder. It accepts a 96-bit fetch window at the expected PC and determines the bundle length (16/32/48/64/96 bits) and lane count from the WEX and prefix bits. It registers the bundle into the decode stage, holds it under pipeline stall, and advances the PC. On branch redirect it discards in-flight fetch data for a fixed drain interval.

## Interface
- `RESET_PC`, default 48'h0, is the expected PC after reset.
- `FLUSH_DRAIN`, default 2, is the number of cycles fetch data is discarded after a redirect (range 1..7).
- Clocking: one clock `clock`; reset `reset` is synchronous and active-low.
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-low.
- `fetchValid` in 1: the fetch window is valid.
- `fetchWord` in 96: the fetch window, with lane A in [31:0], lane B in [63:32] and lane C in [95:64].
- `fetchPc` in 48: the PC of `fetchWord[15:0]`.
- `fetchReady` out 1: the sequencer accepts the window this cycle.
- `fetchNextPc` out 48: the expected PC the fetch unit must supply next.
- `srWxe` in 1: WEX enable.
- `exHold` in 1: the decode stage is stalled.
- `brRedirect` in 1: branch redirect strobe.
- `brPc` in 48: the redirect target.
- `idValid` out 1: a bundle is presented to decode.
- `idWord` out 96: the bundle word, fed to the decoder's `istrWord`.
- `idPc` out 48: the PC of the bundle.
- `idLen` out 3: the bundle length in 16-bit units (1, 2, 3, 4 or 6).
- `idLanes` out 2: the number of lanes issued (1..3).
- `idFault` out 1: illegal bundle; only the legal prefix is issued.
- `bundleCount` out 32: count of bundles issued.

## Operation
- **Length decode** (combinational on `fetchWord`, with A = bits [15:0]):
  - If A[15:13] != 3'b111, the bundle is a 16-bit op: len 1, lanes 1.
  - If A[15:10] is 111011 or 111111 (the EC..EF / FC..FF forms), the bundle is 48 bits: len 3, lanes 1.
  - Otherwise the op is 32-bit. `Df` is bit 10 for the E0..E7 / F0..F7 forms and bit 8 for the E8..EB / F8..FB forms.
  - `Dz` = (A[12] == 0).
  - `Wf` = `Df` && !`Dz` && `srWxe`.
  - If !WfA, the bundle is len 2, lanes 1.
- **Lane B check** (when WfA), on bits [47:32]:
  - If B is not 32-bit, or is an FC-form, set fault with len 2, lanes 1.
  - Otherwise, if !WfB, the bundle is len 4, lanes 2.
- **Lane C check** (when WfB), on bits [79:64]:
  - If C is not 32-bit, or is an FC-form, set fault with len 4, lanes 2.
  - Otherwise the bundle is len 6, lanes 3. Lane C's own Wf is ignored, because 3 lanes is the maximum.
- **Accept rule:** a window is accepted when `fetchReady` && `fetchValid` && `fetchPc` == `fetchNextPc`. A PC-mismatched window is dropped silently.
- `fetchReady` = (state == RUN) && (!`idValid` || !`exHold`) && !`brRedirect`.
- **On accept:**
  - Outputs load on the next edge.
  - `fetchNextPc` += 2*len, mod 2^48.
  - `bundleCount` += 1, wrapping at 2^32.
  - `idWord` = `fetchWord`, unmasked; the decoder ignores unused lanes.
- **Hold:** while `idValid` && `exHold`, all id* outputs are stable.
- **Clear:** when there is no accept and `exHold` = 0, `idValid` clears.
- **States:**
  - BOOT: one cycle after reset, `fetchReady` = 0, then go to RUN.
  - RUN: normal issue.
  - FLUSH: down-counter starts at `FLUSH_DRAIN`, `fetchReady` = 0, returns to RUN when the counter reaches 0.
- **Redirect** (any state):
  - `idValid` is cleared next edge, even under `exHold`.
  - `fetchNextPc` <= `brPc`.
  - State goes to FLUSH and the counter reloads.
  - Redirect beats hold, and beats accept in the same cycle (that fetch window is dropped).

## Timing
- Reset values:
  - `idValid`, `idFault` = 0.
  - `idWord`, `idPc`, `idLen`, `idLanes` = 0.
  - `bundleCount` = 0.
  - `fetchNextPc` = `RESET_PC`.
  - State = BOOT.
  - `fetchReady` = 0.
- Reset mid-hold or mid-FLUSH returns to these reset values.
- Latency:
  - Accept to `idValid` is 1 cycle.
  - Back-to-back accepts are sustained at 1 bundle per cycle when `exHold` = 0.
- After a redirect asserted in cycle t:
  - `idValid` = 0 at t+1.
  - The first possible accept is at t+1+`FLUSH_DRAIN`.
- `fetchNextPc` updates on the same edge that loads `idPc`.
- No combinational path from `exHold` to id* outputs. `fetchReady` depends combinationally on `exHold` and `brRedirect` only.

## Structure
- Shared package (`CoreDefs.v`) holds:
  - the state encodings `JX2_WBI_BOOT`, `JX2_WBI_RUN`, `JX2_WBI_FLUSH`;
  - the length codes;
  - the form masks (the 111011 / 111111 FC-form patterns).
- One natural sub-module, `wex_len_decode`: a purely combinational per-window length, lane and fault decode, reused for all three lane checks.

## Test plan
- 16-bit op: `fetchWord[15:0]` = 16'h3012 at PC 0x1000 → `idLen` = 1, `idLanes` = 1, `fetchNextPc` = 0x1002.
- WEX triple with `srWxe` = 1:
  - A = 0xF4xx, B = 0xF4xx, C = 0xF0xx, with Wf bits as specified, at PC 0x2000.
  - Expect `idLen` = 6, `idLanes` = 3, next PC 0x200C.
  - With `srWxe` = 0: `idLen` = 2, `idLanes` = 1.
- Fault: A WEX-flagged and B = 0xFC00 → `idFault` = 1, `idLen` = 2, `idLanes` = 1, next PC = PC+4.
- Hold then redirect:
  - Issue a bundle, hold `exHold` = 1 for 3 cycles and check outputs stable.
  - Pulse `brRedirect` with `brPc` = 0x8000 while held.
  - Expect `idValid` = 0 next cycle and `fetchReady` = 0 for 2 cycles.
  - Expect a window at 0x8000 accepted on the 3rd cycle.
- Stale PC: present `fetchPc` = 0x1004 while `fetchNextPc` = 0x1002 → no accept, `bundleCount` unchanged.
- Reset mid-FLUSH → all outputs at reset values, BOOT for 1 cycle, accept at `RESET_PC` in the following cycle.

Source files
------------

// File: rtl/wex_bundle_issue_pkg.sv
// Shared definitions for the WEX bundle issue sequencer:
// state encodings, bundle length codes and 48-bit form patterns.
package wex_bundle_issue_pkg;

  localparam logic [1:0] JX2_WBI_BOOT  = 2'd0;
  localparam logic [1:0] JX2_WBI_RUN   = 2'd1;
  localparam logic [1:0] JX2_WBI_FLUSH = 2'd2;

  localparam logic [2:0] LEN_16 = 3'd1;
  localparam logic [2:0] LEN_32 = 3'd2;
  localparam logic [2:0] LEN_48 = 3'd3;
  localparam logic [2:0] LEN_64 = 3'd4;
  localparam logic [2:0] LEN_96 = 3'd6;

  localparam logic [5:0] FORM_EC = 6'b111011;
  localparam logic [5:0] FORM_FC = 6'b111111;

  typedef struct packed {
    logic is32;
    logic is48;
    logic wf;
  } lane_info_t;

endpackage

// File: rtl/wex_len_decode.sv
// Per-lane opcode classification: 32-bit, 48-bit form, and
// WEX-flagged (wide-execute continues into the next lane).
module wex_len_decode
  import wex_bundle_issue_pkg::*;
(
  input  logic [15:0] op,
  input  logic        wxe,
  output lane_info_t  info
);

  logic df;

  // E8..EB / F8..FB carry the flag in bit 8, the rest in bit 10
  assign df = op[11] ? op[8] : op[10];

  always_comb begin
    info.is32 = (op[15:13] == 3'b111);
    info.is48 = (op[15:10] == FORM_EC) ||
                (op[15:10] == FORM_FC);
    info.wf   = info.is32 && !info.is48 &&
                df && op[12] && wxe;
  end

endmodule

// File: rtl/wex_bundle_issue.sv
// Fetch-to-decode issue sequencer for the 3-wide WEX decoder:
// bundle length decode, decode-stage register, PC and flush control.
module wex_bundle_issue
  import wex_bundle_issue_pkg::*;
#(
  parameter logic [47:0] RESET_PC    = 48'h0,
  parameter int          FLUSH_DRAIN = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchValid,
  input  logic [95:0] fetchWord,
  input  logic [47:0] fetchPc,
  output logic        fetchReady,
  output logic [47:0] fetchNextPc,
  input  logic        srWxe,
  input  logic        exHold,
  input  logic        brRedirect,
  input  logic [47:0] brPc,
  output logic        idValid,
  output logic [95:0] idWord,
  output logic [47:0] idPc,
  output logic [2:0]  idLen,
  output logic [1:0]  idLanes,
  output logic        idFault,
  output logic [31:0] bundleCount
);

  logic [1:0] state;
  logic [2:0] cnt;
  lane_info_t a, b, c;
  logic [2:0] len;
  logic [1:0] lanes;
  logic       fault;
  logic       accept;
  logic       unused_cwf;

  wex_len_decode u_dec_a (
    .op   (fetchWord[15:0]),
    .wxe  (srWxe),
    .info (a)
  );

  wex_len_decode u_dec_b (
    .op   (fetchWord[47:32]),
    .wxe  (srWxe),
    .info (b)
  );

  wex_len_decode u_dec_c (
    .op   (fetchWord[79:64]),
    .wxe  (srWxe),
    .info (c)
  );

  // three lanes is the maximum, so lane C's flag never matters
  assign unused_cwf = c.wf;

  always_comb begin
    len   = LEN_16;
    lanes = 2'd1;
    fault = 1'b0;
    if (!a.is32) begin
      len = LEN_16;
    end else if (a.is48) begin
      len = LEN_48;
    end else if (!a.wf) begin
      len = LEN_32;
    end else if (!b.is32 || b.is48) begin
      len   = LEN_32;
      fault = 1'b1;
    end else if (!b.wf) begin
      len   = LEN_64;
      lanes = 2'd2;
    end else if (!c.is32 || c.is48) begin
      len   = LEN_64;
      lanes = 2'd2;
      fault = 1'b1;
    end else begin
      len   = LEN_96;
      lanes = 2'd3;
    end
  end

  assign fetchReady = (state == JX2_WBI_RUN) &&
                      (!idValid || !exHold) &&
                      !brRedirect;

  assign accept = fetchReady && fetchValid &&
                  (fetchPc == fetchNextPc);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= JX2_WBI_BOOT;
      cnt         <= 3'd0;
      fetchNextPc <= RESET_PC;
      idValid     <= 1'b0;
      idWord      <= 96'd0;
      idPc        <= 48'd0;
      idLen       <= 3'd0;
      idLanes     <= 2'd0;
      idFault     <= 1'b0;
      bundleCount <= 32'd0;
    end else if (brRedirect) begin
      idValid     <= 1'b0;
      fetchNextPc <= brPc;
      state       <= JX2_WBI_FLUSH;
      cnt         <= 3'(FLUSH_DRAIN);
    end else begin
      case (state)
        JX2_WBI_BOOT: state <= JX2_WBI_RUN;
        JX2_WBI_FLUSH: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1)
            state <= JX2_WBI_RUN;
        end
        default: ;
      endcase
      if (accept) begin
        idValid     <= 1'b1;
        idWord      <= fetchWord;
        idPc        <= fetchPc;
        idLen       <= len;
        idLanes     <= lanes;
        idFault     <= fault;
        fetchNextPc <= fetchNextPc +
                       {44'd0, len, 1'b0};
        bundleCount <= bundleCount + 32'd1;
      end else if (!exHold) begin
        idValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wex_bundle_issue.sv
// Self-checking bench for wex_bundle_issue: directed vector table,
// hold/redirect/reset sequences and a randomized reference model.
module tb_wex_bundle_issue;

  localparam int FD = 2;

  logic        clock;
  logic        reset;
  logic        fetchValid;
  logic [95:0] fetchWord;
  logic [47:0] fetchPc;
  logic        fetchReady;
  logic [47:0] fetchNextPc;
  logic        srWxe;
  logic        exHold;
  logic        brRedirect;
  logic [47:0] brPc;
  logic        idValid;
  logic [95:0] idWord;
  logic [47:0] idPc;
  logic [2:0]  idLen;
  logic [1:0]  idLanes;
  logic        idFault;
  logic [31:0] bundleCount;

  int checks = 0;
  int errors = 0;

  wex_bundle_issue #(
    .RESET_PC    (48'h0),
    .FLUSH_DRAIN (FD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fetchValid  (fetchValid),
    .fetchWord   (fetchWord),
    .fetchPc     (fetchPc),
    .fetchReady  (fetchReady),
    .fetchNextPc (fetchNextPc),
    .srWxe       (srWxe),
    .exHold      (exHold),
    .brRedirect  (brRedirect),
    .brPc        (brPc),
    .idValid     (idValid),
    .idWord      (idWord),
    .idPc        (idPc),
    .idLen       (idLen),
    .idLanes     (idLanes),
    .idFault     (idFault),
    .bundleCount (bundleCount)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name,
                     input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference classification by opcode high byte
  function automatic bit h_is32(input logic [15:0] h);
    return h[15:8] >= 8'hE0;
  endfunction

  function automatic bit h_is48(input logic [15:0] h);
    return (h[15:8] >= 8'hEC && h[15:8] <= 8'hEF) ||
           h[15:8] >= 8'hFC;
  endfunction

  function automatic bit h_wf(input logic [15:0] h,
                              input bit wxe);
    return wxe && (h[15:8] inside
      {8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hF9, 8'hFB});
  endfunction

  task automatic ref_decode(input logic [95:0] w,
                            input bit wxe,
                            output int len,
                            output int lanes,
                            output bit fault);
    logic [15:0] h;
    logic [15:0] prev;
    len = 1;
    lanes = 1;
    fault = 0;
    h = w[15:0];
    if (!h_is32(h)) return;
    if (h_is48(h)) begin
      len = 3;
      return;
    end
    len = 2;
    for (int k = 1; k <= 2; k++) begin
      prev = w[32*(k-1) +: 16];
      if (!h_wf(prev, wxe)) return;
      h = w[32*k +: 16];
      if (!h_is32(h) || h_is48(h)) begin
        fault = 1;
        return;
      end
      lanes++;
      len += 2;
    end
  endtask

  function automatic logic [15:0] rand_head();
    logic [7:0] hb;
    case ($urandom_range(0, 13))
      0: hb = 8'hF4;
      1: hb = 8'hF5;
      2: hb = 8'hF7;
      3: hb = 8'hF9;
      4: hb = 8'hFB;
      5: hb = 8'hF0;
      6: hb = 8'hF8;
      7: hb = 8'hFC;
      8: hb = 8'hEC;
      9: hb = 8'hE4;
      10: hb = 8'h30;
      default: hb = 8'($urandom);
    endcase
    return {hb, 8'($urandom)};
  endfunction

  typedef struct {
    logic [95:0] word;
    logic        wxe;
    logic [47:0] pc;
    logic [2:0]  len;
    logic [1:0]  lanes;
    logic        fault;
  } vec_t;

  vec_t vecs[10];

  logic [47:0] exp_next;
  logic [31:0] exp_count;

  task automatic redirect(input logic [47:0] pc);
    fetchValid = 1'b0;
    brRedirect = 1'b1;
    brPc = pc;
    step();
    brRedirect = 1'b0;
    repeat (FD) step();
    exp_next = pc;
  endtask

  // model state for the random phase
  bit          m_valid;
  logic [95:0] m_word;
  logic [47:0] m_pc;
  logic [2:0]  m_len;
  logic [1:0]  m_lanes;
  bit          m_fault;
  logic [47:0] m_next;
  logic [31:0] m_count;
  int          m_block;

  initial begin
    int rl, rn;
    bit rf;
    bit fv, hold, redir, wxe, m_ready, m_acc;
    logic [95:0] w;
    logic [47:0] pc, bpc;

    reset = 1'b0;
    fetchValid = 1'b0;
    fetchWord = '0;
    fetchPc = '0;
    srWxe = 1'b0;
    exHold = 1'b0;
    brRedirect = 1'b0;
    brPc = '0;
    step();
    step();
    chk("rst_valid", idValid, 0);
    chk("rst_ready", fetchReady, 0);
    chk("rst_next", fetchNextPc, 0);
    chk("rst_count", bundleCount, 0);
    chk("rst_len", idLen, 0);
    chk("rst_fault", idFault, 0);
    reset = 1'b1;
    step();
    chk("boot_ready", fetchReady, 1);
    exp_next = 48'h0;
    exp_count = 32'h0;

    vecs[0] = '{96'h3012, 1'b1, 48'h1000, 3'd1, 2'd1, 1'b0};
    vecs[1] = '{96'h0000F000_0000F400_0000F400, 1'b1,
                48'h2000, 3'd6, 2'd3, 1'b0};
    vecs[2] = '{96'h0000F000_0000F400_0000F400, 1'b0,
                48'h3000, 3'd2, 2'd1, 1'b0};
    vecs[3] = '{96'h00000000_0000FC00_0000F400, 1'b1,
                48'h4000, 3'd2, 2'd1, 1'b1};
    vecs[4] = '{96'h0000EC12, 1'b1, 48'h4004, 3'd3, 2'd1, 1'b0};
    vecs[5] = '{96'h0000E400, 1'b1, 48'h400A, 3'd2, 2'd1, 1'b0};
    vecs[6] = '{96'h00000000_0000F000_0000F400, 1'b1,
                48'h400E, 3'd4, 2'd2, 1'b0};
    vecs[7] = '{96'h00001234_0000F400_0000F900, 1'b1,
                48'h4016, 3'd4, 2'd2, 1'b1};
    vecs[8] = '{96'h0000F800, 1'b1, 48'h401E, 3'd2, 2'd1, 1'b0};
    vecs[9] = '{96'h0000EC00_0000F400_0000F400, 1'b1,
                48'h4022, 3'd4, 2'd2, 1'b1};

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pc != exp_next) redirect(vecs[i].pc);
      fetchValid = 1'b1;
      fetchWord = vecs[i].word;
      fetchPc = vecs[i].pc;
      srWxe = vecs[i].wxe;
      step();
      fetchValid = 1'b0;
      exp_next = vecs[i].pc + {44'd0, vecs[i].len, 1'b0};
      exp_count++;
      chk($sformatf("v%0d_valid", i), idValid, 1);
      chk($sformatf("v%0d_len", i), idLen, vecs[i].len);
      chk($sformatf("v%0d_lanes", i), idLanes, vecs[i].lanes);
      chk($sformatf("v%0d_fault", i), idFault, vecs[i].fault);
      chk($sformatf("v%0d_pc", i), idPc, vecs[i].pc);
      chk($sformatf("v%0d_word", i), idWord, vecs[i].word);
      chk($sformatf("v%0d_next", i), fetchNextPc, exp_next);
      chk($sformatf("v%0d_count", i), bundleCount, exp_count);
    end

    // hold then redirect
    fetchValid = 1'b1;
    fetchWord = 96'h1111;
    fetchPc = 48'h402A;
    step();
    exp_count++;
    exHold = 1'b1;
    fetchWord = 96'h2222;
    fetchPc = 48'h402C;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", fetchReady, 0);
      step();
      chk("hold_valid", idValid, 1);
      chk("hold_pc", idPc, 48'h402A);
      chk("hold_word", idWord, 96'h1111);
      chk("hold_next", fetchNextPc, 48'h402C);
    end
    brRedirect = 1'b1;
    brPc = 48'h8000;
    #1;
    chk("redir_ready", fetchReady, 0);
    step();
    chk("redir_valid", idValid, 0);
    chk("redir_next", fetchNextPc, 48'h8000);
    brRedirect = 1'b0;
    exHold = 1'b0;
    fetchPc = 48'h8000;
    fetchWord = 96'h3012;
    #1;
    chk("flush_ready1", fetchReady, 0);
    step();
    chk("flush_ready2", fetchReady, 0);
    chk("flush_valid", idValid, 0);
    step();
    chk("flush_run", fetchReady, 1);
    step();
    exp_count++;
    chk("flush_acc", idValid, 1);
    chk("flush_pc", idPc, 48'h8000);
    chk("flush_next", fetchNextPc, 48'h8002);

    // stale PC dropped
    fetchPc = 48'h8004;
    step();
    chk("stale_valid", idValid, 0);
    chk("stale_count", bundleCount, exp_count);
    chk("stale_next", fetchNextPc, 48'h8002);

    // reset during flush
    fetchValid = 1'b0;
    brRedirect = 1'b1;
    brPc = 48'h9000;
    step();
    brRedirect = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("rf_valid", idValid, 0);
    chk("rf_pc", idPc, 0);
    chk("rf_word", idWord, 0);
    chk("rf_len", idLen, 0);
    chk("rf_lanes", idLanes, 0);
    chk("rf_count", bundleCount, 0);
    chk("rf_next", fetchNextPc, 0);
    reset = 1'b1;
    fetchValid = 1'b1;
    fetchPc = 48'h0;
    fetchWord = 96'h3012;
    #1;
    chk("rf_boot", fetchReady, 0);
    step();
    chk("rf_noacc", idValid, 0);
    chk("rf_run", fetchReady, 1);
    step();
    chk("rf_acc", idValid, 1);
    chk("rf_accpc", idPc, 0);
    chk("rf_accnext", fetchNextPc, 48'h2);
    chk("rf_acccount", bundleCount, 1);

    // randomized phase against the reference model
    fetchValid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    m_valid = 0;
    m_word = '0;
    m_pc = '0;
    m_len = '0;
    m_lanes = '0;
    m_fault = 0;
    m_next = 48'h0;
    m_count = 32'h0;
    m_block = 1;
    for (int i = 0; i < 400; i++) begin
      fv = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 3) == 0);
      redir = ($urandom_range(0, 19) == 0);
      wxe = 1'($urandom_range(0, 1));
      w = {16'($urandom), rand_head(),
           16'($urandom), rand_head(),
           16'($urandom), rand_head()};
      pc = ($urandom_range(0, 4) == 0) ? m_next + 48'd2 : m_next;
      bpc = {16'($urandom), 31'($urandom), 1'b0};
      fetchValid = fv;
      exHold = hold;
      brRedirect = redir;
      srWxe = wxe;
      fetchWord = w;
      fetchPc = pc;
      brPc = bpc;
      #1;
      m_ready = (m_block == 0) && (!m_valid || !hold) && !redir;
      chk("rnd_ready", fetchReady, m_ready);
      m_acc = m_ready && fv && (pc == m_next);
      if (redir) begin
        m_valid = 0;
        m_next = bpc;
        m_block = FD;
      end else begin
        if (m_block > 0) m_block--;
        if (m_acc) begin
          ref_decode(w, wxe, rl, rn, rf);
          m_valid = 1;
          m_word = w;
          m_pc = pc;
          m_len = 3'(rl);
          m_lanes = 2'(rn);
          m_fault = rf;
          m_next = m_next + 48'(2 * rl);
          m_count++;
        end else if (!hold) begin
          m_valid = 0;
        end
      end
      step();
      chk("rnd_valid", idValid, m_valid);
      chk("rnd_word", idWord, m_word);
      chk("rnd_pc", idPc, m_pc);
      chk("rnd_len", idLen, m_len);
      chk("rnd_lanes", idLanes, m_lanes);
      chk("rnd_fault", idFault, m_fault);
      chk("rnd_next", fetchNextPc, m_next);
      chk("rnd_count", bundleCount, m_count);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
